// File: rtl/rnn_output_collector.sv
// Samples the recurrent core's Y0/Y1 once per step and groups the 4 steps of a sequence into a frame.
// Whole frames are buffered in a word FIFO and leave as a 4-beat valid/ready stream.
module rnn_output_collector #(
    parameter int W            = 18,
    parameter int DEPTH_FRAMES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     y0_in,
    input  logic [W-1:0]     y1_in,
    input  logic             capture_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y0,
    output logic [W-1:0]     out_y1,
    output logic [1:0]       out_step,
    output logic             out_last,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overflow
);
    localparam int WORDS = 4 * DEPTH_FRAMES;
    localparam int AW    = $clog2(WORDS);
    localparam logic [AW:0] WORDS_C = (AW + 1)'(WORDS);
    localparam logic [AW:0] FRAME_C = (AW + 1)'(4);
    localparam logic [1:0]  PH_COMMIT = 2'd0;
    localparam logic [1:0]  PH_START  = 2'd1;

    logic [2*W-1:0]   mem [WORDS];

    logic [1:0]       ph_q, ph_d;
    logic             primed_q, primed_d;
    logic             acc_q, acc_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      used_q, used_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [2*W-1:0]   out_data_q;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             overflow_q, overflow_d;

    logic             pop, accept, commit, wr_en;
    logic [AW:0]      pop_ext;
    logic [AW:0]      free_words;

    always_comb begin
        ph_d        = ph_q + 2'd1;
        primed_d    = primed_q;
        acc_d       = acc_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q;
        accept      = 1'b0;
        commit      = 1'b0;
        wr_en       = 1'b0;
        pop         = out_valid_q & out_ready;
        pop_ext     = {{AW{1'b0}}, pop};
        // used_q already holds any in-flight reservation; the same-edge pop counts as free.
        free_words  = WORDS_C - used_q + pop_ext;

        case (ph_q)
            PH_START: begin
                primed_d = 1'b1;
                accept   = capture_en && (free_words >= FRAME_C);
                acc_d    = accept;
                wr_en    = accept;
                if (capture_en && !accept) begin
                    overflow_d = 1'b1;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end
                end
            end
            PH_COMMIT: begin
                commit = primed_q & acc_q;
                wr_en  = commit;
                acc_d  = 1'b0;
                if (commit) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: wr_en = acc_q;
        endcase

        wptr_d      = wptr_q + {{(AW - 1){1'b0}}, wr_en};
        rptr_d      = rptr_q + {{(AW - 1){1'b0}}, pop};
        used_d      = used_q + (accept ? FRAME_C : '0) - pop_ext;
        cnt_d       = cnt_q + (commit ? FRAME_C : '0) - pop_ext;
        // A frame committed on this edge becomes visible one edge later.
        out_valid_d = (cnt_q != pop_ext);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ph_q        <= '0;
            primed_q    <= 1'b0;
            acc_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            used_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            primed_q    <= primed_d;
            acc_q       <= acc_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            used_q      <= used_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            mem[wptr_q] <= {y0_in, y1_in};
        end
    end

    // Registered head read; holds while stalled or empty so out_* stay stable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_q <= '0;
        end else if (out_valid_d) begin
            out_data_q <= mem[rptr_d];
        end
    end

    assign out_valid = out_valid_q;
    assign out_y0    = out_data_q[2*W-1:W];
    assign out_y1    = out_data_q[W-1:0];
    assign out_step  = rptr_q[1:0];
    assign out_last  = &rptr_q[1:0];
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_rnn_output_collector.sv
// Bench for rnn_output_collector: directed scenarios plus random soak, checked every
// cycle against a frame/queue model of the collector.
module tb_rnn_output_collector;
    localparam int W            = 18;
    localparam int DEPTH_FRAMES = 4;
    localparam int CNT_W        = 16;
    localparam int WORDS        = 4 * DEPTH_FRAMES;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     y0_in, y1_in;
    logic             capture_en;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_y0, out_y1;
    logic [1:0]       out_step;
    logic             out_last;
    logic [CNT_W-1:0] frame_cnt, drop_cnt;
    logic             overflow;

    rnn_output_collector #(.W(W), .DEPTH_FRAMES(DEPTH_FRAMES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .y0_in(y0_in), .y1_in(y1_in),
        .capture_en(capture_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_y0(out_y0), .out_y1(out_y1), .out_step(out_step), .out_last(out_last),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y0;
        logic [W-1:0] y1;
        int           step;
    } beat_t;

    // Model: vis = beats the consumer can see, pend = committed this edge, stg = in-flight frame.
    beat_t vis[$];
    beat_t pend[$];
    beat_t stg[$];
    int    m_ph;
    bit    m_primed, m_acc, m_in_reset, m_ovf;
    int    m_frames, m_drops;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    dut_beats;
    int    fidx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        beat_t b;
        bit    pop, commit;
        int    free_w;
        if (!reset) begin
            vis.delete(); pend.delete(); stg.delete();
            m_ph = 0; m_primed = 0; m_acc = 0; m_ovf = 0;
            m_frames = 0; m_drops = 0; m_in_reset = 1;
            return;
        end
        m_in_reset = 0;
        pop    = (vis.size() > 0) && out_ready;
        free_w = WORDS - (vis.size() + pend.size() + (m_acc ? 4 : 0)) + (pop ? 1 : 0);
        b.y0   = y0_in;
        b.y1   = y1_in;
        b.step = (m_ph + 3) % 4;
        commit = 0;
        if (m_ph == 1) begin
            m_primed = 1;
            stg.delete();
            if (capture_en && free_w >= 4) begin
                m_acc = 1;
                stg.push_back(b);
            end else begin
                m_acc = 0;
                if (capture_en) begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end else if (m_ph == 0) begin
            if (m_primed && m_acc) begin
                stg.push_back(b);
                commit   = 1;
                m_frames = (m_frames + 1) % 65536;
            end
            m_acc = 0;
        end else if (m_acc) begin
            stg.push_back(b);
        end
        if (pop) void'(vis.pop_front());
        foreach (pend[i]) vis.push_back(pend[i]);
        pend.delete();
        if (commit) begin
            pend = stg;
            stg.delete();
        end
        m_ph = (m_ph + 1) % 4;
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(vis.size() > 0));
        if (m_in_reset) begin
            chk("rst_out_y0", 32'(out_y0), 32'(0));
            chk("rst_out_y1", 32'(out_y1), 32'(0));
            chk("rst_out_step", 32'(out_step), 32'(0));
            chk("rst_out_last", 32'(out_last), 32'(0));
        end else if (vis.size() > 0) begin
            chk("out_y0", 32'(out_y0), 32'(vis[0].y0));
            chk("out_y1", 32'(out_y1), 32'(vis[0].y1));
            chk("out_step", 32'(out_step), 32'(vis[0].step));
            chk("out_last", 32'(out_last), 32'(vis[0].step == 3));
        end
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic drive_y(input bit pat);
        int step;
        if (pat) begin
            step  = (m_ph + 3) % 4;
            y0_in = W'(18'h01000 + step);
            y1_in = W'(-step);
        end else begin
            y0_in = W'($urandom);
            y1_in = W'($urandom);
        end
    endtask

    task automatic tick();
        if (out_valid && out_ready) dut_beats++;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n, input bit pat);
        repeat (n) begin
            drive_y(pat);
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        run(n, 0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; capture_en = 1'b0; out_ready = 1'b0;
        y0_in = '0; y1_in = '0; dut_beats = 0;

        // Patterned samples streamed straight through.
        do_reset(3);
        capture_en = 1'b1; out_ready = 1'b1;
        run(5, 1);
        chk("t1_frame_cnt_first", 32'(frame_cnt), 32'(1));
        run(12, 1);

        // Fill with consumer stalled: 4 frames fit, the 5th is dropped.
        do_reset(2);
        capture_en = 1'b1; out_ready = 1'b0;
        run(21, 0);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'(4));
        chk("t2_drop_cnt", 32'(drop_cnt), 32'(1));
        chk("t2_overflow", 32'(overflow), 32'(1));
        capture_en = 1'b0; out_ready = 1'b1; dut_beats = 0;
        run(20, 0);
        chk("t2_beats", 32'(dut_beats), 32'(16));

        // capture_en low only at the start of frame 2.
        do_reset(2);
        out_ready = 1'b1; fidx = 0;
        repeat (17) begin
            if (m_ph == 1) fidx++;
            capture_en = !(m_ph == 1 && fidx == 2);
            drive_y(0);
            tick();
        end
        chk("t3_frame_cnt", 32'(frame_cnt), 32'(3));
        chk("t3_drop_cnt", 32'(drop_cnt), 32'(0));

        // Full FIFO, single pop at the frame-start edge: still dropped.
        do_reset(2);
        capture_en = 1'b1; out_ready = 1'b0;
        run(17, 0);
        out_ready = 1'b1;
        run(1, 0);
        out_ready = 1'b0;
        chk("t4a_drop_cnt", 32'(drop_cnt), 32'(1));
        chk("t4a_frame_cnt", 32'(frame_cnt), 32'(4));

        // Full FIFO, fourth consecutive pop lands on the frame-start edge: accepted.
        do_reset(2);
        capture_en = 1'b1; out_ready = 1'b0;
        run(18, 0);
        out_ready = 1'b1;
        run(4, 0);
        out_ready = 1'b0;
        run(3, 0);
        chk("t4b_frame_cnt", 32'(frame_cnt), 32'(5));
        chk("t4b_drop_cnt", 32'(drop_cnt), 32'(1));

        // Three-cycle consumer stall mid-frame.
        do_reset(2);
        capture_en = 1'b1; out_ready = 1'b1;
        run(7, 0);
        out_ready = 1'b0;
        run(3, 0);
        chk("t5_step_hold", 32'(out_step), 32'(1));
        out_ready = 1'b1;
        run(14, 0);

        // Reset at step 2 of the third frame with two frames buffered.
        do_reset(2);
        capture_en = 1'b1; out_ready = 1'b0;
        run(11, 0);
        reset = 1'b0;
        run(1, 0);
        chk("t6_out_valid", 32'(out_valid), 32'(0));
        chk("t6_frame_cnt", 32'(frame_cnt), 32'(0));
        reset = 1'b1; out_ready = 1'b1;
        run(12, 0);

        // Random soak of enable and backpressure.
        repeat (300) begin
            capture_en = ($urandom_range(0, 9) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            drive_y(0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
